exec_seq_ctrl: RTL and testbench
================================

# exec_seq_ctrl

Pipeline sequencer for the two-deep registered execute stage (operand flops, then result flops). It owns the valid/ready handshakes between decode, execute and memory, and resolves RAW hazards by forwarding or interlock. It also turns a resolved jump into a one-shot front-end redirect plus flush. It drives the capture enable of the execute flops and carries no datapath of its own beyond the redirect target.

## Interface
- XLEN, 32, datapath/PC width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode offers an instruction
- id_ready  out  1  instruction accepted this cycle when id_valid && id_ready
- id_rs1, id_rs2  in  5  source register indices
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_rd  in  5  destination index
- id_rd_we  in  1  instruction writes id_rd
- id_is_branch  in  1  instruction is branch/jump (drives branch_op)
- ex_capture  out  1  load enable for both execute flop ranks
- ex_jump_flag  in  1  registered jump flag from execute result rank
- ex_jump_target  in  XLEN  registered jump target from execute result rank
- fwd_a_sel, fwd_b_sel  out  1  1 = operand A/B takes registered ALU result instead of register file
- mem_valid  out  1  result rank holds a live instruction
- mem_ready  in  1  memory stage accepts
- mem_rd  out  5  destination of S2 instruction
- mem_rd_we  out  1  write enable of S2 instruction
- redirect_valid  out  1  one-cycle front-end redirect
- redirect_pc  out  XLEN  redirect target
- flush_id  out  1  kill instruction currently in decode

## Operation
- Internal state: S1 = {v, rd, rd_we, is_br}, operands in flight; S2 = {v, rd, rd_we, is_br, redir_done}, result registered.
- adv = !S2.v || mem_ready; ex_capture = adv.
- On adv: S2 <= S1, with v cleared if S1 was killed this cycle; S1 <= accepted ID instruction, or bubble (v=0) if none accepted.
- A bubble in S1 loads is_br=0, so a bubble never reaches S2 with a jump.
- mem_valid = S2.v; mem_rd/mem_rd_we = S2 fields; retire = mem_valid && mem_ready.
- Redirect: fires when S2.v && S2.is_br && ex_jump_flag && !S2.redir_done.
  - redirect_valid=1, redirect_pc=ex_jump_target, flush_id=1.
  - S1.v cleared; redir_done set.
  - Fires exactly once per branch, even while stalled by mem_ready=0.
- The branch itself still retires to memory for link writeback.
- ex_jump_flag is ignored when S2 is not a valid branch.
- Hazard match: (id_uses_rs1 && id_rs1==X.rd) or the same for rs2, with X.v && X.rd_we && X.rd!=0.
- Match on S1 (result not yet registered): stall, id_ready=0.
- Match on S2 only: forward, fwd_x_sel=1 per matching source. Register x0 never forwards.
- id_ready = rstn && adv && !stall && !redirect_valid.
- fwd_*_sel are meaningful only on accept cycles and are 0 otherwise.

## Timing
- Reset (asynchronous): S1.v=S2.v=0, redir_done=0. All outputs 0: id_ready, ex_capture, fwd_*, mem_*, redirect_*, flush_id.
- First cycle after rstn rises: id_ready=1 if id_valid.
- Latency: accept at edge N, result visible at mem_valid after edge N+1.
- Throughput: 1 instruction/cycle with no hazards and mem_ready held high.
- S1 RAW hazard costs exactly 1 bubble. The consumer then forwards from S2.
- Taken jump: redirect 1 cycle after the branch enters S2. The branch penalty is the S1 and ID instructions killed (2 slots).
- mem_ready=0: nothing advances, ex_capture=0, and S1/S2 plus the execute flops hold.
- Simultaneous redirect and id_valid: no accept, flush_id kills the ID instruction.
- Simultaneous redirect and S1 hazard: redirect wins.
- Reset mid-operation: all in-flight instructions dropped; a pending redirect is aborted and is not re-fired after reset.

## Configuration
- EXEC_SEQ_FWD_EN defined: forwarding from S2 as above.
- EXEC_SEQ_FWD_EN undefined:
  - fwd_a_sel=fwd_b_sel=0 constant.
  - Any match on S1 or S2 stalls.
  - The register file is write-through on retire, so the consumer proceeds the cycle after the producer retires.
  - A back-to-back dependency costs 2 bubbles.

## Test plan
- Independent stream, mem_ready=1: rd=1,2,3,4 issued back-to-back -> id_ready stays 1, mem_valid high 4 consecutive cycles, mem_rd=1,2,3,4 in order.
- Dependency: rd=5 then rs1=5 -> with FWD_EN, 1-cycle id_ready=0 stall then fwd_a_sel=1 on accept; without it, 2 stall cycles, fwd_a_sel=0. rd=0 producer -> no stall.
- Taken branch, ex_jump_target=0x0000_0100 -> redirect_valid/flush_id high exactly 1 cycle with redirect_pc=0x100; next S1 instruction never reaches mem_valid; the branch retires.
- Taken branch in S2 with mem_ready=0 for 3 cycles -> redirect fires once on the first cycle, S2 held, mem_valid=1 throughout, branch retires when mem_ready=1.
- Backpressure: mem_ready=0 for 4 cycles mid-stream -> ex_capture=0, id_ready=0, no instruction lost or duplicated after release.
- rstn pulsed low with S1/S2 valid and redirect pending -> all outputs 0 immediately, no redirect after release, id_ready=1 next cycle.

Source files
------------

// File: rtl/exec_seq_if.sv
// exec_seq_if: handshake/control bundle between decode, the execute-stage
// sequencer and the memory stage.
//   master : sequencer side (exec_seq_ctrl). It drives id_ready, ex_capture,
//            fwd_*, mem_*, redirect_* and flush_id.
//   slave  : environment side (decode / execute flops / memory / front end).
interface exec_seq_if #(parameter int XLEN = 32);
    logic            id_valid;
    logic            id_ready;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [4:0]      id_rd;
    logic            id_rd_we;
    logic            id_is_branch;
    logic            ex_capture;
    logic            ex_jump_flag;
    logic [XLEN-1:0] ex_jump_target;
    logic            fwd_a_sel;
    logic            fwd_b_sel;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic            mem_rd_we;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_id;

    modport master (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_rd_we,
               id_is_branch, ex_jump_flag, ex_jump_target, mem_ready,
        output id_ready, ex_capture, fwd_a_sel, fwd_b_sel, mem_valid, mem_rd,
               mem_rd_we, redirect_valid, redirect_pc, flush_id
    );

    modport slave (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_rd_we,
               id_is_branch, ex_jump_flag, ex_jump_target, mem_ready,
        input  id_ready, ex_capture, fwd_a_sel, fwd_b_sel, mem_valid, mem_rd,
               mem_rd_we, redirect_valid, redirect_pc, flush_id
    );
endinterface

// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl: sequencer for the two-deep registered execute stage.
// Tracks the instruction in the operand rank (S1) and in the result rank (S2),
// runs the decode->execute->memory handshakes, resolves RAW hazards by
// interlock (and by forwarding from S2 when enabled), and turns a resolved
// jump in S2 into a one-shot redirect plus decode flush.
// Ports:
//   clk   : clock
//   rstn  : asynchronous active-low reset
//   bus   : exec_seq_if.master (decode handshake, execute capture/forward
//           selects, memory handshake, redirect/flush)
// Build option:
//   EXEC_SEQ_FWD_EN : when defined, operands forward from S2; when undefined,
//                     any match on S1 or S2 stalls until the producer retires
//                     (the register file is write-through on retire).
module exec_seq_ctrl (
    input  logic         clk,
    input  logic         rstn,
    exec_seq_if.master   bus
);
    // S1: operands in flight
    logic       r_s1_v, r_s1_we, r_s1_br;
    logic [4:0] r_s1_rd;
    // S2: result registered
    logic       r_s2_v, r_s2_we, r_s2_br, r_s2_done;
    logic [4:0] r_s2_rd;

    logic w_adv, w_redirect, w_stall, w_accept;
    logic w_s1_a, w_s1_b, w_s2_a, w_s2_b;

    function automatic logic f_match(input logic v, input logic we, input logic [4:0] rd,
                                     input logic uses, input logic [4:0] rs);
        // x0 is hardwired zero: never a dependency
        return v && we && (rd != 5'd0) && uses && (rs == rd);
    endfunction

    always_comb begin
        w_s1_a = f_match(r_s1_v, r_s1_we, r_s1_rd, bus.id_uses_rs1, bus.id_rs1);
        w_s1_b = f_match(r_s1_v, r_s1_we, r_s1_rd, bus.id_uses_rs2, bus.id_rs2);
        w_s2_a = f_match(r_s2_v, r_s2_we, r_s2_rd, bus.id_uses_rs1, bus.id_rs1);
        w_s2_b = f_match(r_s2_v, r_s2_we, r_s2_rd, bus.id_uses_rs2, bus.id_rs2);

        w_adv      = !r_s2_v || bus.mem_ready;
        // redir_done keeps a stalled branch from redirecting twice
        w_redirect = r_s2_v && r_s2_br && bus.ex_jump_flag && !r_s2_done;
`ifdef EXEC_SEQ_FWD_EN
        w_stall    = w_s1_a || w_s1_b;
`else
        w_stall    = w_s1_a || w_s1_b || w_s2_a || w_s2_b;
`endif

        // rstn gating keeps every output at 0 while reset is asserted
        bus.id_ready       = rstn && w_adv && !w_stall && !w_redirect;
        w_accept           = bus.id_valid && bus.id_ready;
        bus.ex_capture     = rstn && w_adv;
`ifdef EXEC_SEQ_FWD_EN
        bus.fwd_a_sel      = w_accept && w_s2_a;
        bus.fwd_b_sel      = w_accept && w_s2_b;
`else
        bus.fwd_a_sel      = 1'b0;
        bus.fwd_b_sel      = 1'b0;
`endif
        bus.mem_valid      = r_s2_v;
        bus.mem_rd         = r_s2_rd;
        bus.mem_rd_we      = r_s2_we;
        bus.redirect_valid = w_redirect;
        bus.redirect_pc    = w_redirect ? bus.ex_jump_target : '0;
        bus.flush_id       = w_redirect;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_v    <= 1'b0;
            r_s1_we   <= 1'b0;
            r_s1_br   <= 1'b0;
            r_s1_rd   <= 5'd0;
            r_s2_v    <= 1'b0;
            r_s2_we   <= 1'b0;
            r_s2_br   <= 1'b0;
            r_s2_done <= 1'b0;
            r_s2_rd   <= 5'd0;
        end else if (w_adv) begin
            // S1 killed by a redirect this cycle moves on as a bubble
            r_s2_v    <= r_s1_v && !w_redirect;
            r_s2_we   <= r_s1_we;
            r_s2_br   <= r_s1_br;
            r_s2_rd   <= r_s1_rd;
            r_s2_done <= 1'b0;
            r_s1_v    <= w_accept;
            r_s1_we   <= w_accept && bus.id_rd_we;
            r_s1_br   <= w_accept && bus.id_is_branch;
            r_s1_rd   <= w_accept ? bus.id_rd : 5'd0;
        end else if (w_redirect) begin
            // stalled branch: kill S1 in place and remember the redirect
            r_s1_v    <= 1'b0;
            r_s2_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_exec_seq_ctrl.sv
module tb_exec_seq_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;

    exec_seq_if #(.XLEN(32)) bus ();
    exec_seq_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

`ifdef EXEC_SEQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // drive one decode slot (tasks start and end at a negedge)
    task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic br,
                         input logic u1, input logic [4:0] rs1, input logic u2, input logic [4:0] rs2);
        bus.id_valid = v; bus.id_rd = rd; bus.id_rd_we = we; bus.id_is_branch = br;
        bus.id_uses_rs1 = u1; bus.id_rs1 = rs1; bus.id_uses_rs2 = u2; bus.id_rs2 = rs2;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 5'd1, 1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.id_ready !== 1'b0) begin failures++; $display("FAIL reset_id_ready got=%b exp=0", bus.id_ready); end
        checks++; if (bus.ex_capture !== 1'b0) begin failures++; $display("FAIL reset_ex_capture got=%b exp=0", bus.ex_capture); end
        checks++; if ({bus.mem_valid, bus.mem_rd_we, bus.mem_rd} !== 7'd0) begin failures++; $display("FAIL reset_mem got=%b exp=0", {bus.mem_valid, bus.mem_rd_we, bus.mem_rd}); end
        checks++; if ({bus.redirect_valid, bus.flush_id, bus.fwd_a_sel, bus.fwd_b_sel} !== 4'd0) begin failures++; $display("FAIL reset_redir got=%b exp=0", {bus.redirect_valid, bus.flush_id, bus.fwd_a_sel, bus.fwd_b_sel}); end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.id_ready); end
        checks++; if (bus.ex_capture !== 1'b1) begin failures++; $display("FAIL reset_release_capture got=%b exp=1", bus.ex_capture); end
        bus.id_valid = 1'b0;   // withdraw the offer before the edge
        @(negedge clk);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1, 5'(i + 1), 1, 0, 0, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (i < 4) begin
                checks++; if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=1", i, bus.id_ready); end
            end
            if (i >= 2 && i < 6) begin
                checks++; if (bus.mem_valid !== 1'b1 || bus.mem_rd !== 5'(i - 1)) begin failures++; $display("FAIL stream_mem cyc=%0d got v=%b rd=%0d exp v=1 rd=%0d", i, bus.mem_valid, bus.mem_rd, i - 1); end
            end else begin
                checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL stream_mem_idle cyc=%0d got=%b exp=0", i, bus.mem_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dependency();
        int stalls = 0;
        bit got = 0;
        // producer rd=5, consumer reads rs1=5 the next cycle
        drive(1, 5'd5, 1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL dep_prod_ready got=%b exp=1", bus.id_ready); end
        @(negedge clk);
        drive(1, 5'd6, 1, 0, 1, 5'd5, 0, 0);
        for (int k = 0; k < 6 && !got; k++) begin
            #1;
            if (bus.id_ready === 1'b1) begin
                got = 1;
                checks++; if (bus.fwd_a_sel !== FWD || bus.fwd_b_sel !== 1'b0) begin failures++; $display("FAIL dep_fwd got a=%b b=%b exp a=%b b=0", bus.fwd_a_sel, bus.fwd_b_sel, FWD); end
            end else begin
                stalls++;
                checks++; if (bus.fwd_a_sel !== 1'b0) begin failures++; $display("FAIL dep_stall_fwd got=%b exp=0", bus.fwd_a_sel); end
            end
            @(negedge clk);
        end
        checks++; if (got !== 1'b1 || stalls != (FWD ? 1 : 2)) begin failures++; $display("FAIL dep_stalls got accepted=%b stalls=%0d exp accepted=1 stalls=%0d", got, stalls, FWD ? 1 : 2); end
        idle(3);
        // x0 producer never creates a dependency
        drive(1, 5'd0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd9, 1, 0, 1, 5'd0, 1, 5'd0);
        #1;
        checks++; if (bus.id_ready !== 1'b1 || bus.fwd_a_sel !== 1'b0 || bus.fwd_b_sel !== 1'b0) begin failures++; $display("FAIL dep_x0 got rdy=%b a=%b b=%b exp rdy=1 a=0 b=0", bus.id_ready, bus.fwd_a_sel, bus.fwd_b_sel); end
        @(negedge clk);
        idle(3);
        // producer two slots ahead (in S2), consumer reads it on rs2
        drive(1, 5'd7, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd8, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd10, 1, 0, 1, 5'd3, 1, 5'd7);
        #1;
        checks++; if (bus.id_ready !== FWD || bus.fwd_b_sel !== FWD || bus.fwd_a_sel !== 1'b0) begin failures++; $display("FAIL dep_s2_rs2 got rdy=%b a=%b b=%b exp rdy=%b a=0 b=%b", bus.id_ready, bus.fwd_a_sel, bus.fwd_b_sel, FWD, FWD); end
        bus.id_valid = 1'b0;
        @(negedge clk);
        idle(4);
    endtask

    task automatic test_branch();
        bus.ex_jump_flag = 1'b1;
        bus.ex_jump_target = 32'h0000_0100;
        drive(1, 5'd1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd2, 1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.redirect_valid !== 1'b0 || bus.id_ready !== 1'b1) begin failures++; $display("FAIL br_no_s2 got redir=%b rdy=%b exp redir=0 rdy=1", bus.redirect_valid, bus.id_ready); end
        @(negedge clk);
        drive(1, 5'd3, 1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.redirect_valid !== 1'b1 || bus.flush_id !== 1'b1 || bus.redirect_pc !== 32'h100) begin failures++; $display("FAIL br_fire got v=%b fl=%b pc=%h exp v=1 fl=1 pc=00000100", bus.redirect_valid, bus.flush_id, bus.redirect_pc); end
        checks++; if (bus.id_ready !== 1'b0 || bus.mem_valid !== 1'b1 || bus.mem_rd !== 5'd1) begin failures++; $display("FAIL br_retire got rdy=%b mv=%b rd=%0d exp rdy=0 mv=1 rd=1", bus.id_ready, bus.mem_valid, bus.mem_rd); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.redirect_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin failures++; $display("FAIL br_after cyc=%0d got redir=%b mv=%b exp 0 0", k, bus.redirect_valid, bus.mem_valid); end
            @(negedge clk);
        end
        bus.ex_jump_flag = 1'b0;
    endtask

    task automatic test_branch_stall();
        bus.ex_jump_flag = 1'b1;
        bus.ex_jump_target = 32'h0000_0100;
        drive(1, 5'd1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd2, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd3, 1, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.redirect_valid !== (k == 0) || bus.flush_id !== (k == 0)) begin failures++; $display("FAIL brs_redir cyc=%0d got v=%b fl=%b exp %b", k, bus.redirect_valid, bus.flush_id, k == 0); end
            checks++; if (bus.mem_valid !== 1'b1 || bus.mem_rd !== 5'd1 || bus.ex_capture !== 1'b0 || bus.id_ready !== 1'b0) begin failures++; $display("FAIL brs_hold cyc=%0d got mv=%b rd=%0d cap=%b rdy=%b exp 1 1 0 0", k, bus.mem_valid, bus.mem_rd, bus.ex_capture, bus.id_ready); end
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_rd !== 5'd1 || bus.redirect_valid !== 1'b0 || bus.ex_capture !== 1'b1) begin failures++; $display("FAIL brs_release got mv=%b rd=%0d redir=%b cap=%b exp 1 1 0 1", bus.mem_valid, bus.mem_rd, bus.redirect_valid, bus.ex_capture); end
        @(negedge clk);
        #1;
        checks++; if (bus.mem_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL brs_killed got mv=%b redir=%b exp 0 0", bus.mem_valid, bus.redirect_valid); end
        @(negedge clk);
        bus.ex_jump_flag = 1'b0;
        idle(2);
    endtask

    task automatic test_backpressure();
        int nxt = 1;
        int ret[$];
        for (int c = 0; c < 20; c++) begin
            bus.mem_ready = !(c >= 3 && c <= 6);
            if (nxt <= 6) drive(1, 5'(nxt), 1, 0, 0, 0, 0, 0);
            else          drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (c >= 3 && c <= 6) begin
                checks++; if (bus.ex_capture !== 1'b0 || bus.id_ready !== 1'b0 || bus.mem_valid !== 1'b1) begin failures++; $display("FAIL bp_hold cyc=%0d got cap=%b rdy=%b mv=%b exp 0 0 1", c, bus.ex_capture, bus.id_ready, bus.mem_valid); end
            end
            if (bus.id_valid && bus.id_ready) nxt++;
            if (bus.mem_valid && bus.mem_ready) ret.push_back(int'(bus.mem_rd));
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        checks++; if (ret.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", ret.size()); end
        for (int i = 0; i < ret.size() && i < 6; i++) begin
            checks++; if (ret[i] != i + 1) begin failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, ret[i], i + 1); end
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        bus.ex_jump_flag = 1'b0;
        bus.ex_jump_target = 32'h0000_0200;
        drive(1, 5'd1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd2, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        // branch in S2, S1 valid; jump resolves just as reset hits
        drive(1, 5'd3, 1, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b0;
        #1;
        checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_mv got=%b exp=1", bus.mem_valid); end
        bus.ex_jump_flag = 1'b1;
        rstn = 1'b0;
        #1;
        checks++; if ({bus.id_ready, bus.ex_capture, bus.mem_valid, bus.mem_rd_we, bus.mem_rd} !== 9'd0) begin failures++; $display("FAIL rst_mid_outs got=%b exp=0", {bus.id_ready, bus.ex_capture, bus.mem_valid, bus.mem_rd_we, bus.mem_rd}); end
        checks++; if ({bus.redirect_valid, bus.flush_id, bus.fwd_a_sel, bus.fwd_b_sel} !== 4'd0 || bus.redirect_pc !== 32'd0) begin failures++; $display("FAIL rst_mid_redir got=%b pc=%h exp=0", {bus.redirect_valid, bus.flush_id, bus.fwd_a_sel, bus.fwd_b_sel}, bus.redirect_pc); end
        @(negedge clk);
        rstn = 1'b1;
        bus.mem_ready = 1'b1;
        drive(1, 5'd4, 1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.id_ready !== 1'b1 || bus.redirect_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin failures++; $display("FAIL rst_after got rdy=%b redir=%b mv=%b exp 1 0 0", bus.id_ready, bus.redirect_valid, bus.mem_valid); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.redirect_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin failures++; $display("FAIL rst_after2 got redir=%b mv=%b exp 0 0", bus.redirect_valid, bus.mem_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_rd !== 5'd4) begin failures++; $display("FAIL rst_after3 got mv=%b rd=%0d exp 1 4", bus.mem_valid, bus.mem_rd); end
        @(negedge clk);
        bus.ex_jump_flag = 1'b0;
        idle(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b1;
        bus.ex_jump_flag = 1'b0;
        bus.ex_jump_target = '0;
        test_reset();
        test_stream();
        test_dependency();
        test_branch();
        test_branch_stall();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
